// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencer feeding a 2-entry {pc, instr} buffer toward decode,
// with redirect handling that waits out an in-flight cache miss before retargeting.
module fetch_unit #(
  parameter int                XLEN      = 32,
  parameter logic [XLEN-1:0]   RESET_PC  = '0,
  parameter int                BUF_DEPTH = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic [XLEN-1:0] o_Addr,
  input  logic [31:0]     i_Data,
  input  logic            i_Stall,
  input  logic            i_Redirect,
  input  logic [XLEN-1:0] i_RedirectPC,
  output logic            o_Valid,
  output logic [31:0]     o_Instr,
  output logic [XLEN-1:0] o_PC,
  input  logic            i_Ready
);
  typedef enum logic {FETCH, DRAIN} state_t;
  localparam logic [1:0] FULL = 2'(BUF_DEPTH);
  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, pend_q, pend_d, pc0_q, pc0_d, pc1_q, pc1_d;
  logic [31:0]     ins0_q, ins0_d, ins1_q, ins1_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            pop, push, full;
  logic [XLEN-1:0] tgt;
  assign tgt     = i_RedirectPC & ~XLEN'(3);
  assign full    = cnt_q == FULL;
  assign o_Addr  = pc_q;
  assign o_Valid = cnt_q != 2'd0;
  assign o_Instr = ins0_q;
  assign o_PC    = pc0_q;
  assign pop     = o_Valid & i_Ready;
  assign push    = (state_q == FETCH) & ~i_Stall & ~i_Redirect & (~full | pop);
  // Head lives in slot 0; a pop shifts slot 1 down, a push lands in the first free slot after that shift.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    pc0_d   = pc0_q;
    ins0_d  = ins0_q;
    pc1_d   = pc1_q;
    ins1_d  = ins1_q;
    if (state_q == FETCH) begin
      if (i_Redirect) begin
        cnt_d   = '0;
        pc_d    = i_Stall ? pc_q : tgt;
        pend_d  = i_Stall ? tgt : pend_q;
        state_d = i_Stall ? DRAIN : FETCH;
      end else begin
        if (pop) begin
          pc0_d  = pc1_q;
          ins0_d = ins1_q;
        end
        if (push) begin
          pc_d = pc_q + XLEN'(4);
          if (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop)) begin
            pc0_d  = pc_q;
            ins0_d = i_Data;
          end else begin
            pc1_d  = pc_q;
            ins1_d = i_Data;
          end
        end
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
      end
    end else begin
      // The refill still targets the old address; the latest redirect wins when it completes.
      pend_d  = i_Redirect ? tgt : pend_q;
      pc_d    = i_Stall ? pc_q : (i_Redirect ? tgt : pend_q);
      state_d = i_Stall ? DRAIN : FETCH;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      cnt_q   <= '0;
      pc0_q   <= '0;
      ins0_q  <= '0;
      pc1_q   <= '0;
      ins1_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      pc0_q   <= pc0_d;
      ins0_q  <= ins0_d;
      pc1_q   <= pc1_d;
      ins1_q  <= ins1_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus random traffic, checked against a queue-based reference.
module tb_fetch_unit;
  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] o_Addr, i_Data, i_RedirectPC, o_Instr, o_PC;
  logic        i_Stall, i_Redirect, o_Valid, i_Ready;
  logic [31:0] dkey = 32'hA5A5_A5A5;
  int          n_cmp = 0, n_err = 0;
  typedef struct {logic [31:0] pc; logic [31:0] ins;} ent_t;
  ent_t        q[$];
  logic [31:0] m_pc, m_pend;
  bit          m_drain;
  fetch_unit dut (
    .i_clk(i_clk), .i_rst(i_rst), .o_Addr(o_Addr), .i_Data(i_Data),
    .i_Stall(i_Stall), .i_Redirect(i_Redirect), .i_RedirectPC(i_RedirectPC),
    .o_Valid(o_Valid), .o_Instr(o_Instr), .o_PC(o_PC), .i_Ready(i_Ready)
  );
  always #5 i_clk = ~i_clk;
  assign i_Data = o_Addr ^ dkey;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    q.delete();
    m_pc    = 32'h0;
    m_pend  = 32'h0;
    m_drain = 0;
  endtask
  // One clock: compare current outputs, apply inputs, advance the model, step to the next falling edge.
  task automatic cycle(input bit red, input logic [31:0] rpc, input bit stall, input bit rdy);
    logic [31:0] t;
    bit          pop;
    chk("addr", o_Addr, m_pc);
    chk("valid", 32'(o_Valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("pc", o_PC, q[0].pc);
      chk("instr", o_Instr, q[0].ins);
    end
    i_Redirect = red; i_RedirectPC = rpc; i_Stall = stall; i_Ready = rdy;
    t   = rpc & 32'hFFFF_FFFC;
    pop = (q.size() != 0) && rdy;
    if (!m_drain) begin
      if (red) begin
        q.delete();
        if (stall) begin m_pend = t; m_drain = 1; end
        else m_pc = t;
      end else begin
        if (pop) void'(q.pop_front());
        if (!stall && q.size() < 2) begin
          q.push_back('{pc: m_pc, ins: m_pc ^ dkey});
          m_pc = m_pc + 32'd4;
        end
      end
    end else begin
      if (red) m_pend = t;
      if (!stall) begin m_pc = m_pend; m_drain = 0; end
    end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask
  initial begin
    i_rst = 1'b0; i_Stall = 0; i_Redirect = 0; i_RedirectPC = '0; i_Ready = 0;
    model_reset();
    repeat (2) @(negedge i_clk);
    chk("rst_valid", 32'(o_Valid), 32'h0);
    chk("rst_addr", o_Addr, 32'h0);
    i_rst = 1'b1;
    repeat (8) cycle(0, 0, 0, 1);
    repeat (5) cycle(0, 0, 0, 0);
    chk("full_hold_addr", o_Addr, m_pc);
    repeat (6) cycle(0, 0, 0, 1);
    cycle(1, 32'h10, 0, 1);
    repeat (5) cycle(0, 0, 1, 1);
    chk("stall_addr", o_Addr, 32'h10);
    repeat (3) cycle(0, 0, 0, 1);
    repeat (3) cycle(0, 0, 0, 0);
    cycle(1, 32'h103, 0, 1);
    chk("redir_flush", 32'(o_Valid), 32'h0);
    chk("redir_addr", o_Addr, 32'h100);
    cycle(0, 0, 0, 1);
    chk("redir_pc", o_PC, 32'h100);
    repeat (2) cycle(0, 0, 0, 1);
    cycle(1, 32'h40, 0, 1);
    cycle(0, 0, 1, 1);
    cycle(1, 32'h200, 1, 1);
    cycle(1, 32'h300, 1, 1);
    cycle(0, 0, 1, 1);
    chk("drain_addr", o_Addr, 32'h40);
    cycle(0, 0, 0, 1);
    chk("drain_next", o_Addr, 32'h300);
    repeat (3) cycle(0, 0, 0, 1);
    cycle(1, 32'hFFFF_FFFE, 0, 1);
    cycle(0, 0, 0, 1);
    chk("wrap", o_Addr, 32'h0);
    repeat (2) cycle(0, 0, 0, 1);
    cycle(1, 32'h500, 1, 1);
    cycle(0, 0, 1, 1);
    #2 i_rst = 1'b0;
    #1;
    chk("async_rst_addr", o_Addr, 32'h0);
    chk("async_rst_valid", 32'(o_Valid), 32'h0);
    model_reset();
    i_Stall = 0; i_Redirect = 0;
    @(negedge i_clk);
    i_rst = 1'b1;
    repeat (4) cycle(0, 0, 0, 1);
    for (int i = 0; i < 400; i++) begin
      if (($urandom & 32'h1F) == 0) dkey = $urandom;
      cycle(($urandom & 7) == 0, $urandom, ($urandom & 3) == 0, $urandom_range(0, 1) == 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, meaning the instruction buffer depth in entries; only value 2 is supported.
REQ-003 SHALL have port i_clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port o_Addr  output  XLEN  fetch address; drives the instruction cache address input.
REQ-006 SHALL have port i_Data  input  32  instruction word returned by the cache for o_Addr.
REQ-007 SHALL have port i_Stall  input  1  cache stall; i_Data is valid only in a cycle where i_Stall=0.
REQ-008 SHALL have port i_Redirect  input  1  branch/jump/trap redirect request, one-cycle pulse.
REQ-009 SHALL have port i_RedirectPC  input  XLEN  redirect target, sampled when i_Redirect=1.
REQ-010 SHALL have port o_Valid  output  1  buffer head holds a valid instruction for decode.
REQ-011 SHALL have port o_Instr  output  32  instruction at the buffer head.
REQ-012 SHALL have port o_PC  output  XLEN  address of o_Instr.
REQ-013 SHALL have port i_Ready  input  1  decode accepts the head entry when o_Valid=1 and i_Ready=1.

Function
REQ-014 SHALL hold a PC register and drive o_Addr = PC combinationally from it; PC[1:0] is always 2'b00.
REQ-015 SHALL hold a 2-entry FIFO of {pc, instr}; o_Valid = (count!=0); o_Instr/o_PC = head entry.
REQ-016 SHALL pop the head in any cycle with o_Valid=1 and i_Ready=1.
REQ-017 SHALL push {PC, i_Data} and set PC <= PC+4 in a cycle with state FETCH, i_Stall=0, no redirect, and (count<2 or pop this cycle); simultaneous push and pop keeps count unchanged.
REQ-018 SHALL hold PC and push nothing when the FIFO is full and no pop occurs, even though the cache reports a hit.
REQ-019 SHALL implement states FETCH and DRAIN; DRAIN means a redirect arrived during a cache miss.
REQ-020 SHALL, in FETCH with i_Redirect=1 and i_Stall=0, flush the FIFO (count <= 0), set PC <= {i_RedirectPC[XLEN-1:2], 2'b00}, push nothing, and ignore any pop that cycle.
REQ-021 SHALL, in FETCH with i_Redirect=1 and i_Stall=1, flush the FIFO, latch the aligned target into a pending register, keep PC (and o_Addr) unchanged, and move to DRAIN.
REQ-022 SHALL keep o_Addr stable in every cycle with i_Stall=1; the cache refill writes to the index/tag of o_Addr.
REQ-023 SHALL, in DRAIN, overwrite the pending target on any further i_Redirect=1 and push nothing.
REQ-024 SHALL, in DRAIN with i_Stall=0, discard i_Data, set PC <= pending target, and return to FETCH.
REQ-025 SHALL make redirect have priority over push, pop, and PC increment in the same cycle.
REQ-026 SHALL have a latency of one cycle from an accepted hit to o_Valid=1 (registered FIFO), and of two cycles from a redirect in FETCH (cache hit) to o_Valid=1 with o_PC equal to the target.
REQ-027 SHALL wrap PC from 32'hFFFF_FFFC to 32'h0000_0000 modulo 2^XLEN, with no flag.
REQ-028 SHALL keep o_Instr/o_PC stable while o_Valid=1 and i_Ready=0.

Reset
REQ-029 SHALL, while i_rst=0 and asynchronously, set PC=RESET_PC, count=0, state=FETCH, pending target=0, giving o_Valid=0 and o_Addr=RESET_PC.
REQ-030 SHALL, on a reset asserted mid-miss or in DRAIN, discard all buffered and pending state; the first fetch after release is from RESET_PC.

Verification
REQ-031 SHALL pass this scenario: reset release, cache always hits with i_Data=addr^32'hA5A5_A5A5, i_Ready=1 -> o_PC sequence 0,4,8,... one per cycle with o_Valid=1 from cycle 2.
REQ-032 SHALL pass this scenario: i_Ready=0 with hits -> count reaches 2, PC stops at 8, o_Addr holds 8, head stays PC 0; i_Ready=1 -> resumes with no loss or duplication.
REQ-033 SHALL pass this scenario: i_Stall=1 for 5 cycles at PC 0x10 -> o_Addr=0x10 throughout, no push; i_Stall=0 -> entry {0x10, i_Data} pushed.
REQ-034 SHALL pass this scenario: redirect to 0x103 in FETCH with 2 entries buffered -> o_Valid=0 next cycle, o_Addr=0x100, o_PC=0x100 two cycles after the redirect.
REQ-035 SHALL pass this scenario: redirect to 0x200 then 0x300 during a 4-cycle miss at 0x40 -> o_Addr=0x40 until i_Stall=0, the 0x40 word is never output, next o_Addr=0x300.
REQ-036 SHALL pass this scenario: PC=0xFFFF_FFFC with a hit -> next o_Addr=0x0; reset asserted during DRAIN -> o_Addr=RESET_PC immediately, o_Valid=0.
